// File: rtl/sram_controller.sv
// sram_controller: splits one 32-bit load/store from the memory stage into two
// 16-bit accesses to an external 256Kx16 asynchronous SRAM. While a transfer is
// in flight, ready is held low so the pipeline stalls.
module sram_controller #(
   parameter int          ACCESS_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

   localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic        op_wr;
   logic [16:0] word;
   logic [31:0] wdata;
   logic        req, in_phase, last;
   logic        dq_oe;
   logic [15:0] dq_out;
   logic [31:0] offs;
   logic        unused_offs;

   assign req      = wr_en | rd_en;
   assign in_phase = (state == LOW) || (state == HIGH);
   assign last     = (cnt == LAST);
   // Offset from the SRAM window; wraps modulo 2^17 words, byte lane bits dropped.
   assign offs        = address - BASE_ADDR;
   assign unused_offs = ^{offs[31:19], offs[1:0]};

   assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Per-phase cycle counter: runs inside LOW/HIGH, restarts at 0 on each phase entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  cnt <= 4'd0;
      else if (in_phase && !last) cnt <= cnt + 4'd1;
      else                        cnt <= 4'd0;
   end

   // Capture the request in IDLE so inputs may change during the transfer; write wins a tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_wr <= 1'b0;
         word  <= 17'd0;
         wdata <= 32'd0;
      end else if (state == IDLE && req) begin
         op_wr <= wr_en;
         word  <= offs[18:2];
         wdata <= write_data;
      end
   end

   // Load result: sample the bus on the last cycle of each read phase.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) read_data <= 32'd0;
      else if (in_phase && !op_wr && last) begin
         if (state == LOW) read_data[15:0]  <= SRAM_DQ;
         else              read_data[31:16] <= SRAM_DQ;
      end
   end

   // Next state and SRAM strobes; WE_N rises on the last phase cycle with addr/data held.
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      SRAM_ADDR = 18'd0;
      SRAM_CE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      SRAM_WE_N = 1'b1;
      SRAM_UB_N = 1'b0;
      SRAM_LB_N = 1'b0;
      dq_oe     = 1'b0;
      dq_out    = 16'd0;
      case (state)
         IDLE: begin
            ready = ~req;
            if (req) state_nxt = LOW;
         end
         LOW: begin
            SRAM_CE_N = 1'b0;
            SRAM_ADDR = {word, 1'b0};
            if (op_wr) begin
               dq_oe     = 1'b1;
               dq_out    = wdata[15:0];
               SRAM_WE_N = last;
            end else begin
               SRAM_OE_N = 1'b0;
            end
            if (last) state_nxt = HIGH;
         end
         HIGH: begin
            SRAM_CE_N = 1'b0;
            SRAM_ADDR = {word, 1'b1};
            if (op_wr) begin
               dq_oe     = 1'b1;
               dq_out    = wdata[31:16];
               SRAM_WE_N = last;
            end else begin
               SRAM_OE_N = 1'b0;
            end
            if (last) state_nxt = DONE;
         end
         default: begin
            ready     = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 256Kx16 async SRAM.
module tb_sram_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0, rd_en = 1'b0;
   logic [31:0] address = 32'd0, write_data = 32'd0;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] sram_dq;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

   // second instance with ACCESS_CYCLES=3 for the write strobe shape
   logic        wr3 = 1'b0, rd3 = 1'b0;
   logic [31:0] addr3 = 32'd0, wd3 = 32'd0;
   logic [31:0] rdata3;
   logic        ready3;
   wire  [15:0] dq3;
   logic [17:0] a3;
   logic        we3, oe3, ce3, ub3, lb3;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] mem [0:262143];

   logic        rdy_t [0:63];
   logic        we_t  [0:63];
   logic        oe_t  [0:63];
   logic [17:0] sa_t  [0:63];
   logic [15:0] dq_t  [0:63];
   int          done_c;

   sram_controller u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
   );

   sram_controller #(.ACCESS_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .wr_en(wr3), .rd_en(rd3), .address(addr3),
      .write_data(wd3), .read_data(rdata3), .ready(ready3), .SRAM_DQ(dq3),
      .SRAM_ADDR(a3), .SRAM_WE_N(we3), .SRAM_OE_N(oe3),
      .SRAM_CE_N(ce3), .SRAM_UB_N(ub3), .SRAM_LB_N(lb3)
   );

   always #5 clk = ~clk;

   // SRAM model: drives the bus on reads, stores while CE_N/WE_N are low
   assign sram_dq = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'bz;

   always @(negedge clk) begin
      if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] = sram_dq;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present a request now (just after a rising edge), drop it after one cycle
   // and scramble address/data, trace every cycle until ready returns.
   task automatic run_op(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
      wr_en = wr; rd_en = rd; address = a; write_data = d;
      done_c = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         rdy_t[c] = ready; we_t[c] = SRAM_WE_N; oe_t[c] = SRAM_OE_N;
         sa_t[c] = SRAM_ADDR; dq_t[c] = sram_dq;
         if (c > 0 && ready) begin
            done_c = c;
            break;
         end
         @(posedge clk); #1;
         wr_en = 1'b0; rd_en = 1'b0; address = $urandom; write_data = $urandom;
      end
      if (done_c < 0) chk("timeout", 32'd0, 32'd1);
      else begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic oe_any;
      mem[4] = 16'h0; mem[5] = 16'h0; mem[8] = 16'h0; mem[9] = 16'h0;
      mem[18'h3FFFE] = 16'hCAFE;
      mem[18'h3FFFF] = 16'hF00D;

      // reset state
      #12;
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_we", {31'd0, SRAM_WE_N}, 32'd1);
      chk("rst_oe", {31'd0, SRAM_OE_N}, 32'd1);
      chk("rst_ce", {31'd0, SRAM_CE_N}, 32'd1);
      chk("rst_ublb", {30'd0, SRAM_UB_N, SRAM_LB_N}, 32'd0);
      chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
      chk("rst_rdata", read_data, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // write 0xDEADBEEF to 1032 -> word 2, halves 4/5
      run_op(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
      chk("wr_rdy0", {31'd0, rdy_t[0]}, 32'd0);
      chk("wr_done", done_c, 32'd5);
      chk("wr_lo_addr", {14'd0, sa_t[1]}, 32'd4);
      chk("wr_lo_dq", {16'd0, dq_t[1]}, 32'h0000BEEF);
      chk("wr_lo_we", {30'd0, we_t[1], we_t[2]}, 32'd1);
      chk("wr_hi_addr", {14'd0, sa_t[3]}, 32'd5);
      chk("wr_hi_dq", {16'd0, dq_t[4]}, 32'h0000DEAD);
      chk("wr_rdata", read_data, 32'd0);
      chk("mem4", {16'd0, mem[4]}, 32'h0000BEEF);
      chk("mem5", {16'd0, mem[5]}, 32'h0000DEAD);

      // back-to-back read of the same word
      run_op(1'b0, 1'b1, 32'd1032, 32'd0);
      chk("rd_done", done_c, 32'd5);
      chk("rd_lo_start", {14'd0, sa_t[1]}, 32'd4);
      chk("rd_oe", {31'd0, oe_t[1]}, 32'd0);
      chk("rd_data", read_data, 32'hDEADBEEF);

      // both enables: write wins
      run_op(1'b1, 1'b1, 32'd1040, 32'h12345678);
      oe_any = 1'b0;
      for (int c = 0; c <= done_c; c++) if (!oe_t[c]) oe_any = 1'b1;
      chk("both_done", done_c, 32'd5);
      chk("both_oe", {31'd0, oe_any}, 32'd0);
      chk("both_rdata", read_data, 32'hDEADBEEF);
      chk("both_mem", {mem[9], mem[8]}, 32'h12345678);

      // BASE_ADDR-4 wraps to word 0x1FFFF
      run_op(1'b0, 1'b1, 32'd1020, 32'd0);
      chk("wrap_lo", {14'd0, sa_t[1]}, 32'h3FFFE);
      chk("wrap_hi", {14'd0, sa_t[3]}, 32'h3FFFF);
      chk("wrap_data", read_data, 32'hF00DCAFE);

      // low address bits ignored
      run_op(1'b0, 1'b1, 32'd1035, 32'd0);
      chk("lsb_data", read_data, 32'hDEADBEEF);

      // reset in the middle of HIGH of a write
      wr_en = 1'b1; address = 32'd1048; write_data = 32'h11112222;
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_addr", {14'd0, SRAM_ADDR}, 32'd13);
      chk("mid_we", {31'd0, SRAM_WE_N}, 32'd0);
      #1 rst = 1'b0;
      #1;
      chk("ar_we", {31'd0, SRAM_WE_N}, 32'd1);
      chk("ar_ce_oe", {30'd0, SRAM_CE_N, SRAM_OE_N}, 32'd3);
      chk("ar_addr", {14'd0, SRAM_ADDR}, 32'd0);
      chk("ar_rdata", read_data, 32'd0);
      chk("ar_ready", {31'd0, ready}, 32'd1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_ready", {31'd0, ready}, 32'd1);
      chk("post_we", {31'd0, SRAM_WE_N}, 32'd1);
      @(posedge clk); #1;

      // N=3 write strobe: WE_N 0,0,1 per phase, data/address steady
      wr3 = 1'b1; addr3 = 32'd1032; wd3 = 32'hA5A55A5A;
      @(negedge clk);
      chk("n3_rdy0", {31'd0, ready3}, 32'd0);
      @(posedge clk); #1;
      wr3 = 1'b0; addr3 = 32'd0; wd3 = 32'd0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         chk("n3_we", {31'd0, we3}, (c % 3 == 0) ? 32'd1 : 32'd0);
         chk("n3_dq", {16'd0, dq3}, (c <= 3) ? 32'h00005A5A : 32'h0000A5A5);
         chk("n3_addr", {14'd0, a3}, (c <= 3) ? 32'd4 : 32'd5);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("n3_done", {30'd0, ready3, ce3}, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
